// File: rtl/io_command_initiator.sv
// io_command_initiator: takes one IO command at a time from the core and
// presents it to a responder with a REQ/ACK handshake. If the responder
// returns register data in the transfer cycle, that data is handed to the
// register file through a valid/ready writeback port. A REQUEST that waits
// too long without ACK is aborted with a one-cycle Timeout pulse.
//
// Ports
//   clk, async_rst_n, clk_en        : clock, async active-low reset, global enable
//   Cmd_Valid/Cmd_Ready             : command handshake from the core
//   Cmd_ResponseRequested, Cmd_DestReg, Cmd_Data : command payload
//   IO_REQ/IO_ACK                   : request handshake to the responder
//   IO_CommandEn, IO_ResponseRequested, IO_DestRegOut, IO_DataOut : request payload
//   IO_CommandResponse              : responder echo, status only
//   IO_RegResponseFlag, IO_DestRegIn, IO_DataIn : returned register data
//   WB_Valid/WB_Ready, WB_DestReg, WB_Data : writeback to the register file
//   Busy, Timeout                   : status
module io_command_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned DATA_W = 16,
  localparam int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              clk_en,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_ResponseRequested,
  input  logic [TAG_W-1:0]  Cmd_DestReg,
  input  logic [DATA_W-1:0] Cmd_Data,
  output logic              IO_REQ,
  input  logic              IO_ACK,
  output logic              IO_CommandEn,
  output logic              IO_ResponseRequested,
  output logic [TAG_W-1:0]  IO_DestRegOut,
  output logic [DATA_W-1:0] IO_DataOut,
  input  logic              IO_CommandResponse,
  input  logic              IO_RegResponseFlag,
  input  logic [TAG_W-1:0]  IO_DestRegIn,
  input  logic [DATA_W-1:0] IO_DataIn,
  output logic              WB_Valid,
  input  logic              WB_Ready,
  output logic [TAG_W-1:0]  WB_DestReg,
  output logic [DATA_W-1:0] WB_Data,
  output logic              Busy,
  output logic              Timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam bit TO_ENABLED = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WRITEBACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  cmd_data_q, cmd_data_d;
  logic [TAG_W-1:0]   cmd_tag_q, cmd_tag_d;
  logic               cmd_rr_q, cmd_rr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W:0]     cnt_inc;
  logic               to_fire;
  logic               in_request;

  // Responder echo has no behavioural effect; kept only as an observable status input.
  logic unused_status;
  assign unused_status = IO_CommandResponse;

  // One-wider increment so the limit compare works up to 255 without wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign to_fire = TO_ENABLED && (cnt_inc == TO_LIMIT);

  // State and datapath registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_data_q <= '0;
      cmd_tag_q  <= '0;
      cmd_rr_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_data_q <= cmd_data_d;
      cmd_tag_q  <= cmd_tag_d;
      cmd_rr_q   <= cmd_rr_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and next-register logic; nothing advances while clk_en is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_data_d = cmd_data_q;
    cmd_tag_d  = cmd_tag_q;
    cmd_rr_d   = cmd_rr_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clk_en && Cmd_Valid) begin
          cmd_data_d = Cmd_Data;
          cmd_tag_d  = Cmd_DestReg;
          cmd_rr_d   = Cmd_ResponseRequested;
          cnt_d      = '0;
          state_d    = REQUEST;
        end
      end

      REQUEST: begin
        if (clk_en) begin
          // ACK is checked before the limit so a transfer on the limit cycle wins.
          if (IO_ACK) begin
            cmd_data_d = '0;
            cmd_tag_d  = '0;
            cmd_rr_d   = 1'b0;
            if (IO_RegResponseFlag) begin
              wb_data_d = IO_DataIn;
              wb_tag_d  = IO_DestRegIn;
              state_d   = WRITEBACK;
            end else begin
              state_d   = IDLE;
            end
          end else if (to_fire) begin
            timeout_d  = 1'b1;
            cmd_data_d = '0;
            cmd_tag_d  = '0;
            cmd_rr_d   = 1'b0;
            state_d    = IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WRITEBACK: begin
        if (clk_en && WB_Ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  assign in_request           = (state_q == REQUEST);
  assign Cmd_Ready            = (state_q == IDLE);
  assign IO_REQ               = in_request;
  assign IO_CommandEn         = in_request;
  assign IO_ResponseRequested = in_request & cmd_rr_q;
  assign IO_DataOut           = in_request ? cmd_data_q : '0;
  assign IO_DestRegOut        = in_request ? cmd_tag_q : '0;
  assign WB_Valid             = (state_q == WRITEBACK);
  assign WB_Data              = wb_data_q;
  assign WB_DestReg           = wb_tag_q;
  assign Busy                 = (state_q != IDLE);
  assign Timeout              = timeout_q;

endmodule
